// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared state encoding and grant identifiers for mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_Idle = 2'b00,
        S_Cpu  = 2'b01,
        S_Dbg  = 2'b10
    } state_t;

    localparam logic G_Cpu = 1'b0;
    localparam logic G_Dbg = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one memory between the CPU port and a debug/loader port
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 cpu_req,
    input  logic                 cpu_wr,
    input  logic [AddrWidth-1:0] cpu_addr,
    input  logic [DataWidth-1:0] cpu_wdata,
    output logic                 cpu_ack,
    output logic [DataWidth-1:0] cpu_rdata,
    input  logic                 dbg_req,
    input  logic                 dbg_wr,
    input  logic [AddrWidth-1:0] dbg_addr,
    input  logic [DataWidth-1:0] dbg_wdata,
    output logic                 dbg_ack,
    output logic [DataWidth-1:0] dbg_rdata,
    input  logic                 dbg_lock,
    input  logic                 cpu_halt,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    output logic                 mem_wr,
    input  logic [DataWidth-1:0] mem_rdata
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_last_grant;
    logic                   w_eff_last;
    logic [AddrWidth-1:0]   r_mem_addr;
    logic [DataWidth-1:0]   r_mem_wdata;

    // Outputs are combinational from state so a reset cuts a write instantly.
    assign cpu_ack   = (r_state == S_Cpu) & cpu_req;
    assign dbg_ack   = (r_state == S_Dbg) & dbg_req;
    assign mem_wr    = (cpu_ack & cpu_wr) | (dbg_ack & dbg_wr);
    assign cpu_rdata = cpu_ack ? mem_rdata : '0;
    assign dbg_rdata = dbg_ack ? mem_rdata : '0;

    always_comb begin
        mem_addr  = r_mem_addr;
        mem_wdata = r_mem_wdata;
        case (r_state)
            S_Cpu: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            S_Dbg: begin
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
            end
            default: ;
        endcase
    end

    // The access acked this cycle counts as "last served" for the tie break,
    // otherwise the same port would win two ties in a row.
    assign w_eff_last = cpu_ack ? G_Cpu : (dbg_ack ? G_Dbg : r_last_grant);

    always_comb begin
        w_next_state = S_Idle;
        if (cpu_halt && dbg_req) begin
            w_next_state = S_Dbg;
        end else if ((r_state == S_Dbg) && dbg_lock && dbg_req) begin
            w_next_state = S_Dbg;
        end else if (cpu_req && dbg_req) begin
            w_next_state = (w_eff_last == G_Cpu) ? S_Dbg : S_Cpu;
        end else if (cpu_req) begin
            w_next_state = S_Cpu;
        end else if (dbg_req) begin
            w_next_state = S_Dbg;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= S_Idle;
            r_last_grant <= G_Dbg;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_eff_last;
            r_mem_addr   <= mem_addr;
            r_mem_wdata  <= mem_wdata;
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the CPU's single memory (16-bit data, 8-bit address) between the CPU's memory port and a debug/loader port. The loader fills program memory at run time instead of preloading it with `$readmemh`, and it can inspect or patch memory while the CPU is halted. The block sits between the CPU memory interface and the memory instance. It grants one requester per access cycle, alternating between ports when both are waiting, with debug override and locking modes.

## Interface
- `DataWidth`, 16, memory word width
- `AddrWidth`, 8, memory address width

Ports:
- `Clk` in 1: single clock; all state changes on posedge.
- `Reset` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request; held until `cpu_ack`.
- `cpu_wr` in 1: 1 = write, 0 = read.
- `cpu_addr` in AddrWidth
- `cpu_wdata` in DataWidth
- `cpu_ack` out 1: access performed this cycle.
- `cpu_rdata` out DataWidth: read data, valid while `cpu_ack`, else 0.
- `dbg_req`, `dbg_wr`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_rdata`: same semantics as the CPU port.
- `dbg_lock` in 1: while debug holds the grant, keep it across back-to-back debug requests.
- `cpu_halt` in 1: CPU halted; debug gets absolute priority.
- `mem_addr` out AddrWidth
- `mem_wdata` out DataWidth
- `mem_wr` out 1: write strobe; memory writes on posedge `Clk`.
- `mem_rdata` in DataWidth: combinational memory read data for `mem_addr`.

## Operation
- States: S_Idle, S_Cpu, S_Dbg.
- In S_Cpu the CPU port drives the memory. In S_Dbg the debug port drives it. In S_Idle `mem_addr`/`mem_wdata` hold their last value and `mem_wr` = 0.
- `cpu_ack` = (state==S_Cpu) & `cpu_req`. `mem_wr` = `cpu_ack` & `cpu_wr`. The debug port uses the same rule with S_Dbg.
- A dropped request in a grant state is a protocol violation. No write and no ack occur, and the state still advances per the next-grant rule.
- Next-grant rule, evaluated at every posedge in every state:
  - `cpu_halt`=1: debug request wins.
  - Else, state==S_Dbg & `dbg_lock` & `dbg_req`: stay in S_Dbg.
  - Else, both requesting: grant the port not served last (`last_grant` register, reset = debug so the CPU wins the first tie).
  - Else, single requester: grant it.
  - Else: S_Idle.
- `last_grant` updates on every acked access.
- No request is lost. A pending request is served within 2 grant cycles unless `dbg_lock` or `cpu_halt` starves the CPU (intended).

## Timing
- Request sampled at posedge N; ack high during cycle N+1 with `rdata` valid combinationally. The requester sees the ack at posedge N+2.
- A requester may present a new request in the cycle after its ack (keep `req` high, change addr). Back-to-back same-port grants are allowed when the other port is idle: one access per cycle, no bubble.
- From a grant state a switch to the other port takes 0 extra cycles. From S_Idle, first ack is 1 cycle after `req`.
- Reset assertion at any time has immediate effect:
  - state = S_Idle, `last_grant` = debug
  - `cpu_ack` = `dbg_ack` = `mem_wr` = 0, `mem_addr` = 0, `mem_wdata` = 0, both `rdata` = 0
- A write in flight at reset is aborted; no partial write is possible, because `mem_wr` is combinational from state.
- `cpu_halt`/`dbg_lock` changes take effect at the next posedge and never cut a current access.

## Structure
- Shared package `mem_arb_pkg`: state enum (S_Idle=2'b00, S_Cpu=2'b01, S_Dbg=2'b10) and grant-id constants (G_Cpu=1'b0, G_Dbg=1'b1). The CPU test bench references these for waits.
- Single module. The next-grant logic is small enough to stay inline, so no sub-module.

## Test plan
- Reset mid-write: debug write to addr 0x10 with Reset low during the grant cycle. `mem_wr` drops at once, mem[0x10] stays unchanged, and after release the state is S_Idle.
- CPU-only reads: `cpu_req` at cycle 1 for addr 0x00, then 0x01 back-to-back. Acks occur in cycles 2 and 3, and `cpu_rdata` equals mem[0x00] then mem[0x01].
- Simultaneous requests after reset: CPU read 0x05 and debug write 0x05=0xBEEF. CPU is acked first with the old data, debug is acked the next cycle, and a re-read returns 0xBEEF.
- Round-robin under contention: both ports hold `req` for 6 cycles. Acks strictly alternate CPU, debug, CPU, … and each port gets 3.
- Lock: `dbg_lock`=1 with a debug burst of 4 writes 0x20–0x23 while the CPU is requesting. There are 4 consecutive debug acks, then the CPU is acked on the cycle after the lock drops.
- Halt priority: `cpu_halt`=1 with both requesting. Debug is acked every cycle and the CPU is never acked. After `cpu_halt`=0, the CPU is acked within 2 cycles.
